// File: rtl/even_ctr_pkg.sv
// even_ctr_pkg: shared states, counter mode codes and even normalization for the sweep controller and counter
package even_ctr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO,
        S_DONE
    } state_t;

    localparam logic [1:0] C_UP   = 2'b00;
    localparam logic [1:0] C_DOWN = 2'b01;
    localparam logic [1:0] C_HOLD = 2'b11;

    localparam logic [3:0] MIN_EVEN = 4'd0;
    localparam logic [3:0] MAX_EVEN = 4'd14;

    function automatic logic [3:0] even4(input logic [3:0] v);
        return {v[3:1], 1'b0};
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: loadable down-counter that flags the last cycle of an endpoint dwell
module sweep_dwell_timer #(
    parameter int DWELL_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expire
);

    logic [3:0] cnt;

    // reload on dwell entry, then count down to zero and stay there
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= start ? 4'(DWELL_CYCLES) : (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    end

    assign expire = (cnt == 4'd1);

endmodule

// File: rtl/even_sweep_ctrl.sv
// even_sweep_ctrl: drives the even up/down counter through programmed triangle sweeps between two even endpoints
module even_sweep_ctrl
    import even_ctr_pkg::*;
#(
    parameter int DWELL_CYCLES = 3,
    parameter int LOOP_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cfg_lo,
    input  logic [3:0]        cfg_hi,
    input  logic [LOOP_W-1:0] cfg_loops,
    input  logic [3:0]        ctr_count,
    output logic              ctr_load,
    output logic [3:0]        ctr_data,
    output logic              ctr_count_en,
    output logic [1:0]        ctr_c,
    output logic              busy,
    output logic [LOOP_W-1:0] loops_left,
    output logic              done,
    output logic              cfg_err,
    output logic              aborted
);

    state_t      state, state_n;
    logic [3:0]  lo, hi;
    logic        start_ok, accept, tmr_start, expire;

    assign start_ok = even4(cfg_lo) < even4(cfg_hi);
    assign accept   = (state == S_IDLE) && start && start_ok;

    sweep_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (tmr_start),
        .expire (expire)
    );

    // state, endpoint capture, loop bookkeeping and the registered cfg_err/aborted pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lo         <= MIN_EVEN;
            hi         <= MIN_EVEN;
            loops_left <= '0;
            cfg_err    <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_n;
            lo         <= (state == S_IDLE && start) ? even4(cfg_lo) : lo;
            hi         <= (state == S_IDLE && start) ? even4(cfg_hi) : hi;
            loops_left <= accept ? ((cfg_loops == '0) ? LOOP_W'(1) : cfg_loops)
                        : (state_n == S_IDLE || state_n == S_DONE) ? '0
                        : (state == S_DWELL_LO && state_n == S_UP) ? loops_left - LOOP_W'(1)
                        : loops_left;
            cfg_err    <= (state == S_IDLE) && start && !start_ok;
            aborted    <= abort && (state != S_IDLE);
        end
    end

    // next state and counter drive; abort overrides every transition and freezes the counter at once
    always_comb begin
        state_n      = state;
        tmr_start    = 1'b0;
        ctr_load     = (state == S_LOAD);
        ctr_data     = lo;
        ctr_c        = (state == S_UP) ? C_UP : (state == S_DOWN) ? C_DOWN : C_HOLD;
        ctr_count_en = !abort && (((state == S_UP) && (ctr_count != hi)) ||
                                  ((state == S_DOWN) && (ctr_count != lo)));
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        case (state)
            S_IDLE:     state_n = accept ? S_LOAD : S_IDLE;
            S_LOAD:     state_n = S_UP;
            S_UP: begin
                tmr_start = (ctr_count == hi);
                state_n   = (ctr_count == hi) ? S_DWELL_HI : S_UP;
            end
            S_DWELL_HI: state_n = expire ? S_DOWN : S_DWELL_HI;
            S_DOWN: begin
                tmr_start = (ctr_count == lo);
                state_n   = (ctr_count == lo) ? S_DWELL_LO : S_DOWN;
            end
            S_DWELL_LO: state_n = !expire ? S_DWELL_LO : (loops_left == LOOP_W'(1)) ? S_DONE : S_UP;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE)
            state_n = S_IDLE;
    end

endmodule

// File: tb/tb_even_sweep_ctrl.sv
// tb_even_sweep_ctrl: directed sweeps against a behavioural even counter with hand-computed expectations
module tb_even_sweep_ctrl;
    import even_ctr_pkg::*;

    localparam int LOOP_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        cfg_lo = '0;
    logic [3:0]        cfg_hi = '0;
    logic [LOOP_W-1:0] cfg_loops = '0;
    logic [3:0]        ctr_count;
    logic              ctr_load, ctr_count_en, busy, done, cfg_err, aborted;
    logic [3:0]        ctr_data;
    logic [1:0]        ctr_c;
    logic [LOOP_W-1:0] loops_left;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int load_cnt = 0;
    int d0, a0, l0;

    always #5 clk = ~clk;

    even_sweep_ctrl #(.DWELL_CYCLES(3), .LOOP_W(LOOP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cfg_lo       (cfg_lo),
        .cfg_hi       (cfg_hi),
        .cfg_loops    (cfg_loops),
        .ctr_count    (ctr_count),
        .ctr_load     (ctr_load),
        .ctr_data     (ctr_data),
        .ctr_count_en (ctr_count_en),
        .ctr_c        (ctr_c),
        .busy         (busy),
        .loops_left   (loops_left),
        .done         (done),
        .cfg_err      (cfg_err),
        .aborted      (aborted)
    );

    // behavioural even up/down counter driven by the controller
    always @(posedge clk) begin
        if (reset)
            ctr_count <= MIN_EVEN;
        else if (ctr_load)
            ctr_count <= even4(ctr_data);
        else if (ctr_count_en)
            ctr_count <= (ctr_c == C_UP) ? ((ctr_count == MAX_EVEN) ? ctr_count : ctr_count + 4'd2)
                       : (ctr_c == C_DOWN) ? ctr_count - 4'd2 : ctr_count;
    end

    // pulse tallies sampled mid-cycle
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        if (ctr_load) load_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [3:0] lo, input logic [3:0] hi, input logic [LOOP_W-1:0] loops);
        cfg_lo = lo;
        cfg_hi = hi;
        cfg_loops = loops;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // expected per cycle 1..17 for lo=2 hi=8 loops=1: count, {en,c}, {busy,done,load}
    int e_cnt[17] = '{0, 2, 4, 6, 8, 8, 8, 8, 8, 6, 4, 2, 2, 2, 2, 2, 2};
    int e_enc[17] = '{3, 4, 4, 4, 0, 3, 3, 3, 5, 5, 5, 1, 3, 3, 3, 3, 3};
    int e_bdl[17] = '{5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 6, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_c", ctr_c, 3);
        chk("rst_outs", {ctr_load, ctr_count_en, done, cfg_err, aborted}, 0);
        chk("rst_loops", loops_left, 0);
        chk("rst_data", ctr_data, 0);
        reset = 1'b0;
        step();

        go(2, 8, 1);
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("t1_cnt%0d", c), ctr_count, e_cnt[c-1]);
            chk($sformatf("t1_enc%0d", c), {ctr_count_en, ctr_c}, e_enc[c-1]);
            chk($sformatf("t1_bdl%0d", c), {busy, done, ctr_load}, e_bdl[c-1]);
            if (c == 1) chk("t1_data", ctr_data, 2);
            if (c == 16) chk("t1_loops", loops_left, 0);
            if (c < 17) step();
        end

        d0 = done_cnt;
        go(3, 9, 2);
        chk("t2_data", ctr_data, 2);
        chk("t2_loops_c1", loops_left, 2);
        step(14);
        chk("t2_loops_c15", loops_left, 2);
        step();
        chk("t2_loops_c16", loops_left, 1);
        chk("t2_cnt_c16", ctr_count, 2);
        chk("t2_enc_c16", {ctr_count_en, ctr_c}, 4);
        step(3);
        chk("t2_cnt_c19", ctr_count, 8);
        step(10);
        chk("t2_loops_c29", loops_left, 1);
        step();
        chk("t2_done_c30", done, 1);
        chk("t2_loops_c30", loops_left, 0);
        step();
        chk("t2_busy_c31", busy, 0);
        chk("t2_done_pulses", done_cnt - d0, 1);

        l0 = load_cnt;
        go(6, 6, 1);
        chk("t3a_err", cfg_err, 1);
        chk("t3a_busy", busy, 0);
        step();
        chk("t3a_err_clr", cfg_err, 0);
        chk("t3a_busy2", busy, 0);
        go(10, 4, 1);
        chk("t3b_err", cfg_err, 1);
        chk("t3b_busy", busy, 0);
        step();
        chk("t3b_err_clr", cfg_err, 0);
        chk("t3_no_load", load_cnt - l0, 0);

        d0 = done_cnt;
        go(2, 8, 1);
        step(10);
        chk("t4_cnt_c11", ctr_count, 4);
        abort = 1'b1;
        #1;
        chk("t4_abort_en", ctr_count_en, 0);
        step();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_aborted", aborted, 1);
        chk("t4_en", ctr_count_en, 0);
        chk("t4_cnt_hold", ctr_count, 4);
        step();
        chk("t4_aborted_clr", aborted, 0);
        chk("t4_cnt_hold2", ctr_count, 4);
        chk("t4_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        a0 = abort_cnt;
        go(2, 8, 1);
        step(6);
        chk("t5_dwell_hold", {ctr_count_en, ctr_c}, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_c", ctr_c, 3);
        chk("t5_outs", {ctr_load, ctr_count_en, done, cfg_err, aborted}, 0);
        chk("t5_loops", loops_left, 0);
        chk("t5_data", ctr_data, 0);
        chk("t5_no_pulse", (done_cnt - d0) + (abort_cnt - a0), 0);
        go(0, 14, 0);
        chk("t5_loops1", loops_left, 1);
        step(8);
        chk("t5_cnt_top", ctr_count, 14);
        chk("t5_en_top", ctr_count_en, 0);
        step(14);
        chk("t5_loops_c23", loops_left, 1);
        step();
        chk("t5_done_c24", done, 1);
        step();
        chk("t5_idle_c25", busy, 0);
        chk("t5_one_loop", done_cnt - d0, 1);

        d0 = done_cnt;
        go(2, 8, 1);
        step(4);
        cfg_lo = 4'd0;
        cfg_hi = 4'd14;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_busy", busy, 1);
        step(4);
        chk("t6_data", ctr_data, 2);
        chk("t6_cnt_c10", ctr_count, 6);
        step(6);
        chk("t6_done_c16", done, 1);
        step();
        chk("t6_idle_c17", busy, 0);
        a0 = abort_cnt;
        cfg_lo = 4'd4;
        cfg_hi = 4'd6;
        cfg_loops = 1;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_pair_load", ctr_load, 1);
        chk("t6_pair_data", ctr_data, 4);
        chk("t6_pair_aborted", aborted, 0);
        for (int i = 0; i < 100 && busy; i++) step();
        chk("t6_finish_timeout", busy, 0);
        chk("t6_done_pulses", done_cnt - d0, 2);
        chk("t6_no_abort", abort_cnt - a0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
